// File: rtl/addsub_slice_sequencer_if.sv
// Handshake and CLA-slice bus for the sequential add/subtract controller.
// The slave side is the sequencer itself; the master side is the environment,
// which supplies operands, consumes results and hosts the combinational
// CLA slice.
interface addsub_slice_sequencer_if #(
    parameter int WIDTH = 15,
    parameter int SLICE = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;

    logic [SLICE-1:0] cla_a;
    logic [SLICE-1:0] cla_b;
    logic             cla_c0;
    logic [SLICE-1:0] cla_s;
    logic [SLICE-1:0] cla_carry;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready, cla_s, cla_carry,
        input  in_ready, cla_a, cla_b, cla_c0, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready, cla_s, cla_carry,
        output in_ready, cla_a, cla_b, cla_c0, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/addsub_slice_sequencer.sv
// Sequential two's-complement add/subtract built around an external
// combinational CLA slice. One SLICE-wide chunk is presented per cycle, the
// slice carry is chained through a register, and the finished sum is
// published with carry-out and signed overflow on a valid/ready handshake.
// Subtraction is A + ~B + 1: B is inverted at capture time and the +1 enters
// as the carry-in of the lowest slice.
module addsub_slice_sequencer #(
    parameter int WIDTH = 15,
    parameter int SLICE = 3
) (
    input logic                     clk,
    input logic                     rst_n,
    addsub_slice_sequencer_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
    localparam int LO_W   = WIDTH - SLICE;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sub_r;
    logic             c_r;
    logic [IDX_W-1:0] idx;
    logic [LO_W-1:0]  lo_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic             accept;
    logic             last;
    logic             in_ready_c;
    logic             out_valid_c;
    logic [SLICE-1:0] cla_a_c;
    logic [SLICE-1:0] cla_b_c;
    logic             cla_c0_c;

    // State register; an asynchronous reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, handshake flags and the slice presented to the CLA.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        last        = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        cla_a_c     = '0;
        cla_b_c     = '0;
        cla_c0_c    = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                cla_a_c  = a_r[int'(idx)*SLICE +: SLICE];
                cla_b_c  = b_r[int'(idx)*SLICE +: SLICE];
                cla_c0_c = (idx == '0) ? sub_r : c_r;
                if (idx == LAST_IDX) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, per-slice sum accumulation and result publication.
    // The published sum lives in its own register so it stays put while the
    // next transaction is being accumulated in lo_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            sub_r  <= 1'b0;
            c_r    <= 1'b0;
            idx    <= '0;
            lo_r   <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            a_r   <= bus.in_a;
            b_r   <= bus.in_sub ? ~bus.in_b : bus.in_b;
            sub_r <= bus.in_sub;
            idx   <= '0;
        end else if (state == RUN) begin
            c_r <= bus.cla_carry[SLICE-1];
            if (last) begin
                sum_r  <= {bus.cla_s, lo_r};
                cout_r <= bus.cla_carry[SLICE-1];
                ovf_r  <= bus.cla_carry[SLICE-1] ^ bus.cla_carry[SLICE-2];
            end else begin
                lo_r[int'(idx)*SLICE +: SLICE] <= bus.cla_s;
                idx <= idx + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_sum   = sum_r;
    assign bus.out_cout  = cout_r;
    assign bus.out_ovf   = ovf_r;
    assign bus.cla_a     = cla_a_c;
    assign bus.cla_b     = cla_b_c;
    assign bus.cla_c0    = cla_c0_c;
endmodule

// File: tb/tb_addsub_slice_sequencer.sv
// Testbench for addsub_slice_sequencer. Hosts a bit-level CLA slice, keeps a
// transaction-level reference model built from plain integer arithmetic, and
// compares every DUT output against it on each falling edge. Directed
// scenarios additionally pin results to hand-computed literals.
module tb_addsub_slice_sequencer;
    localparam int WIDTH  = 15;
    localparam int SLICE  = 3;
    localparam int NSLICE = WIDTH / SLICE;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    addsub_slice_sequencer_if #(.WIDTH(WIDTH), .SLICE(SLICE)) bus ();

    addsub_slice_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Combinational CLA slice: ripple of generate/propagate per bit.
    logic [SLICE-1:0] slice_s;
    logic [SLICE-1:0] slice_carry;
    logic             slice_c;
    always_comb begin
        slice_s     = '0;
        slice_carry = '0;
        slice_c     = bus.cla_c0;
        for (int i = 0; i < SLICE; i++) begin
            slice_s[i]     = bus.cla_a[i] ^ bus.cla_b[i] ^ slice_c;
            slice_carry[i] = (bus.cla_a[i] & bus.cla_b[i]) | ((bus.cla_a[i] | bus.cla_b[i]) & slice_c);
            slice_c        = slice_carry[i];
        end
    end
    assign bus.cla_s     = slice_s;
    assign bus.cla_carry = slice_carry;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: tracks cycles since the accept edge and the results
    // a 15-bit signed add/subtract must produce.
    bit               m_busy = 1'b0;
    int               m_cyc  = 0;
    int               m_a    = 0;
    int               m_bx   = 0;
    int               m_sub  = 0;
    logic [WIDTH-1:0] e_sum  = '0;
    logic             e_cout = 1'b0;
    logic             e_ovf  = 1'b0;
    logic [WIDTH-1:0] h_sum  = '0;
    logic             h_cout = 1'b0;
    logic             h_ovf  = 1'b0;

    // Advance the model on each rising edge; reset follows rst_n at once.
    always @(posedge clk or negedge rst_n) begin
        int sa, sb, r, u;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_cyc  = 0;
            h_sum  = '0;
            h_cout = 1'b0;
            h_ovf  = 1'b0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                sa     = int'($signed(bus.in_a));
                sb     = int'($signed(bus.in_b));
                r      = bus.in_sub ? sa - sb : sa + sb;
                e_sum  = WIDTH'(r);
                e_ovf  = (r > (1 << (WIDTH - 1)) - 1) || (r < -(1 << (WIDTH - 1)));
                m_a    = int'({17'b0, bus.in_a});
                m_bx   = int'({17'b0, bus.in_sub ? ~bus.in_b : bus.in_b});
                m_sub  = bus.in_sub ? 1 : 0;
                u      = m_a + m_bx + m_sub;
                e_cout = u[WIDTH];
                m_busy = 1'b1;
                m_cyc  = 0;
            end
        end else if (m_cyc < NSLICE) begin
            m_cyc++;
            if (m_cyc == NSLICE) begin
                h_sum  = e_sum;
                h_cout = e_cout;
                h_ovf  = e_ovf;
            end
        end else if (bus.out_ready) begin
            m_busy = 1'b0;
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        int k, mask, ea, eb, ec;
        ea = 0;
        eb = 0;
        ec = 0;
        if (m_busy && m_cyc < NSLICE) begin
            k    = m_cyc * SLICE;
            mask = (1 << k) - 1;
            ea   = (m_a >> k) & ((1 << SLICE) - 1);
            eb   = (m_bx >> k) & ((1 << SLICE) - 1);
            ec   = (((m_a & mask) + (m_bx & mask) + m_sub) >> k) & 1;
        end
        check("in_ready",  32'(bus.in_ready),  32'(!m_busy));
        check("out_valid", 32'(bus.out_valid), 32'(m_busy && m_cyc == NSLICE));
        check("out_sum",   32'(bus.out_sum),   32'(h_sum));
        check("out_cout",  32'(bus.out_cout),  32'(h_cout));
        check("out_ovf",   32'(bus.out_ovf),   32'(h_ovf));
        check("cla_a",     32'(bus.cla_a),     ea);
        check("cla_b",     32'(bus.cla_b),     eb);
        check("cla_c0",    32'(bus.cla_c0),    ec);
    end

    // Present one operand pair and hold it until the DUT takes it.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        bit taken;
        taken        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        for (int n = 0; n < 50 && !taken; n++) begin
            taken = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!taken) check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    // Wait for a result, pin it to literals, then complete the handshake.
    task automatic checkOutput(input string name, input logic [WIDTH-1:0] sum, input logic cout,
                               input logic ovf, input bit check_latency);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_seen"}, 32'(bus.out_valid), 32'd1);
        if (check_latency) check({name, "_latency"}, n, NSLICE);
        check({name, "_sum"},  32'(bus.out_sum),  32'(sum));
        check({name, "_cout"}, 32'(bus.out_cout), 32'(cout));
        check({name, "_ovf"},  32'(bus.out_ovf),  32'(ovf));
        check({name, "_model_sum"},  32'(h_sum),  32'(sum));
        check({name, "_model_cout"}, 32'(h_cout), 32'(cout));
        check({name, "_model_ovf"},  32'(h_ovf),  32'(ovf));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomised soak with output stalls.
    initial begin
        int n, vcount;
        bit acc, hs;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_sum",   32'(bus.out_sum),   32'd0);
        check("reset_cla_c0",    32'(bus.cla_c0),    32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(15'h0005, 15'h0003, 1'b0);
        checkOutput("add_5_3", 15'h0008, 1'b0, 1'b0, 1'b1);
        applyStimulus(15'h3FFF, 15'h0001, 1'b0);
        checkOutput("add_pos_ovf", 15'h4000, 1'b0, 1'b1, 1'b1);
        applyStimulus(15'h7FFF, 15'h7FFF, 1'b0);
        checkOutput("add_m1_m1", 15'h7FFE, 1'b1, 1'b0, 1'b1);
        applyStimulus(15'h0000, 15'h0001, 1'b1);
        checkOutput("sub_0_1", 15'h7FFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(15'h4000, 15'h0001, 1'b1);
        checkOutput("sub_neg_ovf", 15'h3FFF, 1'b1, 1'b1, 1'b1);

        // Stall in DONE; a stray in_valid during RUN must not be captured.
        applyStimulus(15'h1234, 15'h0567, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_a     = 15'h7000;
        bus.in_b     = 15'h7000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
            check("stall_out_sum",   32'(bus.out_sum),   32'h179B);
        end
        checkOutput("stall_result", 15'h179B, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in RUN with slice index 2 showing.
        applyStimulus(15'h7FFF, 15'h7FFF, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_cla_a", 32'(bus.cla_a), 32'd7);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_out_sum",   32'(bus.out_sum),   32'd0);
        check("abort_cla_a",     32'(bus.cla_a),     32'd0);
        check("abort_cla_b",     32'(bus.cla_b),     32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(15'h0005, 15'h0003, 1'b0);
        checkOutput("after_reset_5_3", 15'h0008, 1'b0, 1'b0, 1'b1);

        // out_ready held high and in_valid held across DONE->IDLE.
        bus.out_ready = 1'b1;
        applyStimulus(15'h0100, 15'h0001, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_a     = 15'h2000;
        bus.in_b     = 15'h2000;
        bus.in_sub   = 1'b0;
        n      = 0;
        vcount = 0;
        acc    = 1'b0;
        while (!acc && n < 50) begin
            acc = bus.in_ready;
            if (bus.out_valid) begin
                vcount++;
                check("b2b_first_sum",  32'(bus.out_sum),  32'h00FF);
                check("b2b_first_cout", 32'(bus.out_cout), 32'd1);
                check("b2b_first_ovf",  32'(bus.out_ovf),  32'd0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        check("b2b_accept_spacing", n, NSLICE + 2);
        check("b2b_valid_cycles", vcount, 1);
        checkOutput("b2b_second", 15'h4000, 1'b0, 1'b1, 1'b1);
        bus.out_ready = 1'b0;

        // Random transactions with random consumer stalls, checked by the model.
        for (int t = 0; t < 300; t++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
            hs = 1'b0;
            for (int c = 0; c < 200 && !hs; c++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                hs = bus.out_valid && bus.out_ready;
                @(posedge clk);
                #1;
            end
            if (!hs) check("random_handshake_timeout", 32'd0, 32'd1);
            bus.out_ready = 1'b0;
        end

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
